skein_scan_ctrl: RTL and testbench
==================================

SKEIN_SCAN_CTRL -- requirements
Module: skein_scan_ctrl

Interface
REQ-001 Parameter HASH_LATENCY, default 184: cycles from a nonce presented on nonce_o to its hash on hash_i.
REQ-002 Parameter FIFO_DEPTH, default 4: result FIFO entries, power of two.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  in  1  synchronous, active-low reset.
REQ-005 start  in  1  one-cycle pulse; begins a scan when in IDLE or DONE.
REQ-006 nonce_first  in  32  first nonce of range; sampled on accepted start.
REQ-007 nonce_last  in  32  last nonce of range, inclusive; sampled on accepted start.
REQ-008 target  in  64  threshold; sampled on accepted start.
REQ-009 nonce_o  out  32  nonce driven to the skein512 core.
REQ-010 hash_i  in  512  hash from the skein512 core.
REQ-011 busy  out  1  high in RUN or DRAIN.
REQ-012 done  out  1  high in DONE.
REQ-013 res_valid, res_ready  out/in  1  result handshake.
REQ-014 res_nonce  out  32  nonce whose hash met target.
REQ-015 res_hash_hi  out  64  hash_i[511:448] for that nonce.
REQ-016 overflow  out  1  sticky; a match was dropped because the FIFO was full.

Function
REQ-017 Phase toggle register alternates every cycle from 0 after reset; issue slots are phase=1 cycles only, matching the core's two-block interleave.
REQ-018 States: IDLE, RUN, DRAIN, DONE. IDLE->RUN on start. RUN->DRAIN after the issue slot carrying nonce_last. DRAIN->DONE when the in-flight tracker is empty. DONE->RUN on start.
REQ-019 In RUN, the issue counter loads nonce_first on start and advances by 1 after each issue slot. It wraps 0xFFFFFFFF->0x00000000. A range with nonce_last < nonce_first scans through the wrap.
REQ-020 nonce_o holds the issue counter in RUN and holds its last value otherwise.
REQ-021 In-flight tracker: 1-bit shift register, HASH_LATENCY deep. Shifts in 1 on RUN issue slots, else 0. Its output marks the cycle in which hash_i is valid for a tracked nonce.
REQ-022 Result counter loads nonce_first on start and increments once per tracker output of 1. Its value before increment tags the current hash_i.
REQ-023 Match condition: tracker output is 1 and unsigned hash_i[511:448] <= target. Compare is 64-bit, no sign extension.
REQ-024 Each match pushes {tag, hash_i[511:448]} into the FIFO. The push is registered, so an entry is visible on res_valid one cycle after the match cycle.
REQ-025 FIFO pop occurs when res_valid && res_ready. A simultaneous push and pop on a full FIFO succeeds without loss. A push on a full FIFO without pop is dropped and sets overflow.
REQ-026 Outputs res_nonce and res_hash_hi are stable while res_valid=1 and res_ready=0.
REQ-027 start is ignored in RUN and DRAIN. FIFO contents and overflow persist across a new start.
REQ-028 Latency:
  - busy rises the cycle after start.
  - done rises the cycle after the tracker empties, at least HASH_LATENCY cycles after the last issue.

Reset
REQ-029 On rst_n=0 at a clock edge, the block shall:
  - enter IDLE;
  - clear phase, tracker, FIFO pointers and overflow;
  - zero nonce_o, the issue counter and the result counter;
  - drive res_valid=0, busy=0, done=0.
REQ-030 Reset mid-RUN or mid-DRAIN discards all in-flight tags and queued results. No result is emitted for nonces issued before reset.

Structure
REQ-031 A shared package holds the state enum, the default HASH_LATENCY, and the result struct {nonce 32, hash_hi 64}.
REQ-032 The result FIFO is a single sub-module, skein_result_fifo: synchronous, parameterised depth, full/empty flags, registered outputs.
REQ-033 skein512 is instantiated beside this block, not inside it.

Verification
REQ-034 Range 0x10..0x13, target 0xFFFFFFFFFFFFFFFF -> four results with nonces 0x10,0x11,0x12,0x13 in order; done asserted; overflow=0.
REQ-035 Target 0, model hash_hi nonzero everywhere -> no res_valid; done asserted HASH_LATENCY+O(1) cycles after the last issue.
REQ-036 Range 0xFFFFFFFE..0x00000001, all match, res_ready=1 -> results with nonces 0xFFFFFFFE,0xFFFFFFFF,0x0,0x1.
REQ-037 Range of 8 all matching, res_ready=0 -> FIFO holds the first 4; overflow=1. After res_ready=1, exactly those 4 are delivered.
REQ-038 rst_n=0 for one cycle 20 cycles into RUN, then scan 0x100..0x101 -> only results for 0x100 and 0x101 appear.
REQ-039 Cycle-accurate skein512 in the loop, known midstate/data -> res_hash_hi equals the reference model hash for the tagged nonce, confirming HASH_LATENCY.

Source files
------------

// File: rtl/skein_scan_ctrl_pkg.sv
// Shared types and defaults for the skein512 nonce scan controller.
// Scan FSM states, result record layout and the default core latency.
package skein_scan_ctrl_pkg;

    localparam int HASH_LATENCY_DEFAULT = 184;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } scan_state_t;

    typedef struct packed {
        logic [31:0] nonce;
        logic [63:0] hash_hi;
    } result_t;

    function automatic result_t make_result(input logic [31:0] nonce, input logic [63:0] hash_hi);
        result_t r;
        r.nonce   = nonce;
        r.hash_hi = hash_hi;
        return r;
    endfunction

endpackage

// File: rtl/skein_result_fifo.sv
// Result FIFO with a registered head: out_data/out_valid come straight from flops.
// DEPTH must be a power of two and at least 2; push on full succeeds only with a pop.
module skein_result_fifo
    import skein_scan_ctrl_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    push,
    input  result_t push_data,
    input  logic    pop,
    output logic    out_valid,
    output result_t out_data,
    output logic    full,
    output logic    empty,
    output logic    drop
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    result_t       mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic          out_valid_reg;
    logic          full_reg;
    result_t       out_data_reg;

    logic          pop_ok;
    logic          push_ok;
    logic [CW-1:0] count_next;
    logic [AW-1:0] head_idx;
    result_t       head_next;

    assign pop_ok     = pop && out_valid_reg;
    assign push_ok    = push && (!full_reg || pop_ok);
    assign drop       = push && !push_ok;
    assign count_next = count_reg + CW'(push_ok) - CW'(pop_ok);
    assign head_idx   = pop_ok ? rd_ptr_reg + AW'(1) : rd_ptr_reg;
    // A push into a FIFO that is (or becomes) empty lands directly in the head register.
    assign head_next  = (push_ok && head_idx == wr_ptr_reg) ? push_data : mem[head_idx];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            out_valid_reg <= 1'b0;
            full_reg      <= 1'b0;
            out_data_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            count_reg     <= count_next;
            out_valid_reg <= (count_next != '0);
            full_reg      <= (count_next == CW'(DEPTH));
            if (count_next != '0) begin
                out_data_reg <= head_next;
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign full      = full_reg;
    assign empty     = !out_valid_reg;

endmodule

// File: rtl/skein_scan_ctrl.sv
// Nonce range scanner feeding an interleaved skein512 core; tags returning hashes
// with their nonce and queues those at or below target into a small result FIFO.
module skein_scan_ctrl
    import skein_scan_ctrl_pkg::*;
#(
    parameter int HASH_LATENCY = HASH_LATENCY_DEFAULT,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [31:0]  nonce_first,
    input  logic [31:0]  nonce_last,
    input  logic [63:0]  target,
    output logic [31:0]  nonce_o,
    input  logic [511:0] hash_i,
    output logic         busy,
    output logic         done,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [31:0]  res_nonce,
    output logic [63:0]  res_hash_hi,
    output logic         overflow
);

    scan_state_t             state_reg;
    logic                    phase_reg;
    logic                    busy_reg;
    logic                    done_reg;
    logic                    overflow_reg;
    logic [31:0]             issue_cnt_reg;
    logic [31:0]             nonce_o_reg;
    logic [31:0]             last_reg;
    logic [31:0]             res_cnt_reg;
    logic [63:0]             target_reg;
    logic [HASH_LATENCY-1:0] trk_reg;

    logic        issue;
    logic        trk_out;
    logic [63:0] hash_hi;
    logic        match;
    logic        fifo_full;
    logic        fifo_empty;
    logic        fifo_drop;
    result_t     fifo_head;
    logic        unused_bits;

    // The core accepts a new block only on phase=1 cycles.
    assign issue   = (state_reg == ST_RUN) && phase_reg;
    assign trk_out = trk_reg[HASH_LATENCY-1];
    assign hash_hi = hash_i[511:448];
    assign match   = trk_out && (hash_hi <= target_reg);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            phase_reg     <= 1'b0;
            trk_reg       <= '0;
            issue_cnt_reg <= '0;
            nonce_o_reg   <= '0;
            last_reg      <= '0;
            res_cnt_reg   <= '0;
            target_reg    <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            phase_reg <= ~phase_reg;
            trk_reg   <= {trk_reg[HASH_LATENCY-2:0], issue};
            if (trk_out) begin
                res_cnt_reg <= res_cnt_reg + 32'd1;
            end
            case (state_reg)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_reg     <= ST_RUN;
                        busy_reg      <= 1'b1;
                        done_reg      <= 1'b0;
                        issue_cnt_reg <= nonce_first;
                        nonce_o_reg   <= nonce_first;
                        last_reg      <= nonce_last;
                        target_reg    <= target;
                        res_cnt_reg   <= nonce_first;
                    end
                end
                ST_RUN: begin
                    if (issue) begin
                        issue_cnt_reg <= issue_cnt_reg + 32'd1;
                        // nonce_o keeps showing nonce_last once the range is exhausted.
                        if (issue_cnt_reg == last_reg) begin
                            state_reg <= ST_DRAIN;
                        end else begin
                            nonce_o_reg <= issue_cnt_reg + 32'd1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (trk_reg == '0) begin
                        state_reg <= ST_DONE;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            overflow_reg <= 1'b0;
        end else if (fifo_drop) begin
            overflow_reg <= 1'b1;
        end
    end

    skein_result_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_result_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (match),
        .push_data (make_result(res_cnt_reg, hash_hi)),
        .pop       (res_ready),
        .out_valid (res_valid),
        .out_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .drop      (fifo_drop)
    );

    assign unused_bits = ^{fifo_full, fifo_empty, hash_i[447:0]};

    assign nonce_o     = nonce_o_reg;
    assign busy        = busy_reg;
    assign done        = done_reg;
    assign overflow    = overflow_reg;
    assign res_nonce   = fifo_head.nonce;
    assign res_hash_hi = fifo_head.hash_hi;

endmodule

// File: tb/tb_skein_scan_ctrl.sv
// Scoreboard bench for skein_scan_ctrl with a latency-accurate model of the skein512 core.
// Expected results come from walking each nonce range with the model hash and the target rule.
module tb_skein_scan_ctrl;

    localparam int L     = 184;
    localparam int DEPTH = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [31:0]  nonce_first = '0;
    logic [31:0]  nonce_last = '0;
    logic [63:0]  target = '0;
    logic [31:0]  nonce_o;
    logic [511:0] hash_i;
    logic         busy;
    logic         done;
    logic         res_valid;
    logic         res_ready = 1'b0;
    logic [31:0]  res_nonce;
    logic [63:0]  res_hash_hi;
    logic         overflow;

    int checks = 0;
    int failures = 0;
    int ready_mode = 1;
    logic ovf_model = 1'b0;
    logic [95:0] exp_q[$];

    always #5 clk = ~clk;

    skein_scan_ctrl #(
        .HASH_LATENCY (L),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .nonce_first (nonce_first),
        .nonce_last  (nonce_last),
        .target      (target),
        .nonce_o     (nonce_o),
        .hash_i      (hash_i),
        .busy        (busy),
        .done        (done),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_nonce   (res_nonce),
        .res_hash_hi (res_hash_hi),
        .overflow    (overflow)
    );

    function automatic logic [63:0] model_hash(input logic [31:0] n);
        logic [63:0] x;
        x = {n ^ 32'h5bd1e995, n} * 64'h9E3779B97F4A7C15;
        x = x ^ (x >> 29);
        x = x * 64'hBF58476D1CE4E5B9;
        return x ^ (x >> 32);
    endfunction

    // Core model: hash of whatever nonce was presented L cycles ago; only issue-slot
    // (phase=1) inputs produce a true hash, other cycles return a corrupted value.
    logic        phase_tb = 1'b0;
    logic [31:0] pipe_nonce [L];
    logic        pipe_slot  [L];

    always @(posedge clk) begin
        phase_tb      <= rst_n ? ~phase_tb : 1'b0;
        pipe_nonce[0] <= nonce_o;
        pipe_slot[0]  <= phase_tb & rst_n;
        for (int i = 1; i < L; i++) begin
            pipe_nonce[i] <= pipe_nonce[i-1];
            pipe_slot[i]  <= pipe_slot[i-1];
        end
    end

    assign hash_i = {pipe_slot[L-1] ? model_hash(pipe_nonce[L-1]) : ~model_hash(pipe_nonce[L-1]),
                     {14{pipe_nonce[L-1]}}};

    // Monitor: pops the scoreboard on every accepted result and checks hold-while-stalled.
    logic        stall_prev = 1'b0;
    logic [95:0] held_prev = '0;
    logic [95:0] exp_item;

    always @(negedge clk) begin
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                checks++;
                if (!res_valid || {res_nonce, res_hash_hi} !== held_prev) begin
                    failures++;
                    $display("FAIL hold_while_stalled actual valid=%0b data=%h required valid=1 data=%h",
                             res_valid, {res_nonce, res_hash_hi}, held_prev);
                end
            end
            if (res_valid && res_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_result actual nonce=%h hash_hi=%h required none",
                             res_nonce, res_hash_hi);
                end else begin
                    exp_item = exp_q.pop_front();
                    if ({res_nonce, res_hash_hi} !== exp_item) begin
                        failures++;
                        $display("FAIL result actual nonce=%h hash_hi=%h required nonce=%h hash_hi=%h",
                                 res_nonce, res_hash_hi, exp_item[95:64], exp_item[63:0]);
                    end else begin
                        $display("result nonce=%h hash_hi=%h", res_nonce, res_hash_hi);
                    end
                end
            end
            stall_prev = res_valid && !res_ready;
            held_prev  = {res_nonce, res_hash_hi};
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        case (ready_mode)
            0:       res_ready = 1'b0;
            1:       res_ready = 1'b1;
            default: res_ready = 1'($urandom_range(0, 1));
        endcase
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        exp_q.delete();
        ovf_model = 1'b0;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_res_valid", 64'(res_valid), 64'd0);
        check("reset_nonce_o", 64'(nonce_o), 64'd0);
        check("reset_overflow", 64'(overflow), 64'd0);
    endtask

    // mode 0: res_ready held low until done; 1: held high; 2: random.
    task automatic run_scan(input logic [31:0] first, input logic [31:0] last,
                            input logic [63:0] tgt, input int mode);
        int          n_total;
        int          n_match;
        int          n_exp;
        int          cyc;
        logic [31:0] n;
        n_total = int'(last - first) + 1;
        n_match = 0;
        n_exp   = 0;
        n       = first;
        for (int i = 0; i < n_total; i++) begin
            if (model_hash(n) <= tgt) begin
                n_match++;
                if (mode != 0 || n_exp < DEPTH) begin
                    exp_q.push_back({n, model_hash(n)});
                    n_exp++;
                end
            end
            n = n + 32'd1;
        end
        if (mode == 0 && n_match > DEPTH) begin
            ovf_model = 1'b1;
        end
        $display("scan first=%h last=%h target=%h nonces=%0d matches=%0d expected_results=%0d",
                 first, last, tgt, n_total, n_match, n_exp);

        ready_mode  = mode;
        res_ready   = (mode == 1);
        nonce_first = first;
        nonce_last  = last;
        target      = tgt;
        check("busy_before_start", 64'(busy), 64'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_after_start", 64'(busy), 64'd1);
        check("done_after_start", 64'(done), 64'd0);

        cyc = 1;
        while (!done && cyc < 2 * n_total + L + 40) begin
            tick();
            cyc++;
        end
        check("done_reached", 64'(done), 64'd1);
        checks++;
        if (cyc < 2 * n_total + L || cyc > 2 * n_total + L + 3) begin
            failures++;
            $display("FAIL done_latency actual=%0d required=%0d..%0d",
                     cyc, 2 * n_total + L, 2 * n_total + L + 3);
        end
        check("busy_in_done", 64'(busy), 64'd0);
        check("overflow", 64'(overflow), 64'(ovf_model));

        ready_mode = 1;
        res_ready  = 1'b1;
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 60) begin
            tick();
            cyc++;
        end
        repeat (4) tick();
        check("results_outstanding", 64'(exp_q.size()), 64'd0);
        check("res_valid_after_drain", 64'(res_valid), 64'd0);
    endtask

    initial begin
        logic [31:0] f;
        rst_n = 1'b0;
        repeat (3) tick();
        do_reset();

        run_scan(32'h0000_0010, 32'h0000_0013, 64'hFFFF_FFFF_FFFF_FFFF, 1);
        run_scan(32'h0000_0200, 32'h0000_0205, 64'h0, 1);
        run_scan(32'hFFFF_FFFE, 32'h0000_0001, 64'hFFFF_FFFF_FFFF_FFFF, 1);
        run_scan(32'h0000_0300, 32'h0000_0307, 64'hFFFF_FFFF_FFFF_FFFF, 0);

        // Abort a long scan mid-RUN; nothing from it may ever surface.
        $display("scan first=00000040 last=0000007f aborted by reset");
        ready_mode  = 1;
        nonce_first = 32'h0000_0040;
        nonce_last  = 32'h0000_007F;
        target      = 64'hFFFF_FFFF_FFFF_FFFF;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (20) tick();
        check("busy_mid_run", 64'(busy), 64'd1);
        do_reset();
        run_scan(32'h0000_0100, 32'h0000_0101, 64'hFFFF_FFFF_FFFF_FFFF, 1);

        for (int k = 0; k < 4; k++) begin
            f = $urandom;
            run_scan(f, f + 32'($urandom_range(0, 3)), {$urandom, $urandom}, 2);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        failures++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
